// File: rtl/vs_pkg.sv
// Shared types for the victim store: controller states and the per-slot record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vs_pkg;

    // Line geometry the slot record is laid out for; the store's TAG_W/DATA_W default to these.
    localparam int VS_TAG_W  = 14;
    localparam int VS_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EVICT_WB   = 2'd1,
        FLUSH_SCAN = 2'd2,
        FLUSH_WB   = 2'd3
    } vs_state_t;

    typedef struct packed {
        logic                 vld;
        logic                 dirty;
        logic [VS_TAG_W-1:0]  tag;
        logic [VS_DATA_W-1:0] dat;
    } slot_t;

endpackage

// File: rtl/vs_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest request bit.
// Latency: combinational, zero cycles.
// Backpressure: none; idx is 0 when no request bit is set.
module vs_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/victim_store.sv
// Fully-associative victim store between L1 and memory, with dual lookup and dirty writeback.
// Latency: lookups are combinational; inserts land at the next edge unless a dirty victim must drain first.
// Backpressure: ins_ready drops while a dirty victim or a flush is written back; wb_* held until wb_ready.
module victim_store
    import vs_pkg::*;
#(
    parameter int  ENTRIES = 4,
    parameter int  TAG_W   = VS_TAG_W,
    parameter int  DATA_W  = VS_DATA_W,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [TAG_W-1:0]  ins_tag,
    input  logic              ins_dirty,
    input  logic [DATA_W-1:0] ins_data,

    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_take,
    output logic              i_hit,
    output logic [IW-1:0]     i_idx,
    output logic [DATA_W-1:0] i_data,

    input  logic [TAG_W-1:0]  d_tag,
    input  logic              d_take,
    output logic              d_hit,
    output logic [IW-1:0]     d_idx,
    output logic [DATA_W-1:0] d_data,
    output logic              d_dirty,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,

    input  logic              flush,
    output logic              flush_done,
    output logic [IW:0]       occupancy
);

    slot_t              slots [ENTRIES];
    vs_state_t          state, state_nxt;
    logic [IW-1:0]      rr;
    logic [IW-1:0]      scan_idx;
    logic               flush_pend;

    logic [ENTRIES-1:0] vld_vec, i_match, d_match, ins_match;
    logic               free_any, i_any, d_any, ins_any;
    logic [IW-1:0]      free_idx, i_enc, d_enc, ins_enc;

    logic               full, evict_needed, flush_req, last_slot, scan_dirty;
    logic               ins_fire, wb_fire, ins_replace, scan_step, scan_done;
    logic [IW-1:0]      ins_slot, wb_sel;

    // Per-slot valid vector and tag comparators for the three lookup sources.
    always_comb begin
        vld_vec   = '0;
        i_match   = '0;
        d_match   = '0;
        ins_match = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            vld_vec[k]   = slots[k].vld;
            i_match[k]   = slots[k].vld && (slots[k].tag == i_tag);
            d_match[k]   = slots[k].vld && (slots[k].tag == d_tag);
            ins_match[k] = slots[k].vld && (slots[k].tag == ins_tag);
        end
    end

    vs_prio_enc #(.N(ENTRIES), .IW(IW)) u_free_enc (.req(~vld_vec),  .any(free_any), .idx(free_idx));
    vs_prio_enc #(.N(ENTRIES), .IW(IW)) u_i_enc    (.req(i_match),   .any(i_any),    .idx(i_enc));
    vs_prio_enc #(.N(ENTRIES), .IW(IW)) u_d_enc    (.req(d_match),   .any(d_any),    .idx(d_enc));
    vs_prio_enc #(.N(ENTRIES), .IW(IW)) u_ins_enc  (.req(ins_match), .any(ins_any),  .idx(ins_enc));

    // Zero-latency lookup results; a miss reports index 0 and zero data.
    always_comb begin
        i_hit   = i_any && !rst;
        i_idx   = i_hit ? i_enc : '0;
        i_data  = i_hit ? slots[i_enc].dat : '0;
        d_hit   = d_any && !rst;
        d_idx   = d_hit ? d_enc : '0;
        d_data  = d_hit ? slots[d_enc].dat : '0;
        d_dirty = d_hit ? slots[d_enc].dirty : 1'b0;
    end

    // Controller decision terms, all evaluated on pre-take state.
    always_comb begin
        full         = &vld_vec;
        flush_req    = flush || flush_pend;
        evict_needed = ins_valid && !ins_any && full && slots[rr].dirty;
        last_slot    = (scan_idx == IW'(ENTRIES - 1));
        scan_dirty   = slots[scan_idx].vld && slots[scan_idx].dirty;
        ins_fire     = ins_valid && ins_ready;
        wb_fire      = wb_valid && wb_ready;
        ins_slot     = ins_any ? ins_enc : (free_any ? free_idx : rr);
        ins_replace  = ins_fire && !ins_any && !free_any;
        scan_step    = ((state == FLUSH_SCAN) && !scan_dirty) ||
                       ((state == FLUSH_WB) && wb_fire);
        scan_done    = scan_step && last_slot;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a flush request outranks a dirty eviction since the flush drains that line anyway.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH_SCAN;
                end else if (evict_needed) begin
                    state_nxt = EVICT_WB;
                end
            end
            EVICT_WB: begin
                if (wb_fire) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (scan_dirty) begin
                    state_nxt = FLUSH_WB;
                end else if (last_slot) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH_WB: begin
                if (wb_fire) begin
                    state_nxt = last_slot ? IDLE : FLUSH_SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: insert acceptance and the writeback channel; the offered slot cannot change while offered.
    always_comb begin
        ins_ready = !rst && (state == IDLE) && !evict_needed;
        wb_valid  = !rst && ((state == EVICT_WB) || (state == FLUSH_WB));
        wb_sel    = (state == EVICT_WB) ? rr : scan_idx;
        wb_tag    = slots[wb_sel].tag;
        wb_data   = slots[wb_sel].dat;
    end

    // Slot array, replacement pointer, flush scan and pending-flush bookkeeping; inserts are applied last so they win over takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                slots[k].vld   <= 1'b0;
                slots[k].dirty <= 1'b0;
            end
            rr         <= '0;
            scan_idx   <= '0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= scan_done;

            if (i_take && i_hit) begin
                slots[i_idx].vld   <= 1'b0;
                slots[i_idx].dirty <= 1'b0;
            end
            if (d_take && d_hit) begin
                slots[d_idx].vld   <= 1'b0;
                slots[d_idx].dirty <= 1'b0;
            end

            // A drained victim frees its slot and moves the pointer on so the refill is not the next victim.
            if ((state == EVICT_WB) && wb_fire) begin
                slots[rr].vld   <= 1'b0;
                slots[rr].dirty <= 1'b0;
                rr              <= rr + IW'(1);
            end

            if (scan_step) begin
                slots[scan_idx].vld   <= 1'b0;
                slots[scan_idx].dirty <= 1'b0;
                scan_idx              <= last_slot ? '0 : scan_idx + IW'(1);
            end

            if ((state == IDLE) && flush_req) begin
                flush_pend <= 1'b0;
                scan_idx   <= '0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end

            if (ins_fire) begin
                slots[ins_slot].vld   <= 1'b1;
                slots[ins_slot].tag   <= ins_tag;
                slots[ins_slot].dat   <= ins_data;
                slots[ins_slot].dirty <= ins_any ? (slots[ins_slot].dirty | ins_dirty) : ins_dirty;
                if (ins_replace) begin
                    rr <= rr + IW'(1);
                end
            end
        end
    end

    // Occupancy is the live count of valid slots, so it moves the cycle after any change.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            occupancy = occupancy + {{IW{1'b0}}, vld_vec[k]};
        end
    end

endmodule

// File: tb/tb_victim_store.sv
// Directed bench for victim_store: hand-computed expectations for lookup, insert, eviction, flush and reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: wb_ready driven by the bench; every wait is bounded.
module tb_victim_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid, ins_ready, ins_dirty;
    logic [13:0] ins_tag;
    logic [63:0] ins_data;
    logic [13:0] i_tag, d_tag, wb_tag;
    logic        i_take, i_hit, d_take, d_hit, d_dirty;
    logic [1:0]  i_idx, d_idx;
    logic [63:0] i_data, d_data, wb_data;
    logic        wb_valid, wb_ready, flush, flush_done;
    logic [2:0]  occupancy;

    int          total = 0;
    int          bad   = 0;
    int          wb_cnt;
    logic [13:0] wb_log [8];
    int          pulses;

    victim_store #(.ENTRIES(4), .TAG_W(14), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag),
        .ins_dirty(ins_dirty), .ins_data(ins_data),
        .i_tag(i_tag), .i_take(i_take), .i_hit(i_hit), .i_idx(i_idx), .i_data(i_data),
        .d_tag(d_tag), .d_take(d_take), .d_hit(d_hit), .d_idx(d_idx), .d_data(d_data),
        .d_dirty(d_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush), .flush_done(flush_done), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Log every accepted writeback in order.
    always @(posedge clk) begin
        if (rst) begin
            wb_cnt <= 0;
        end else if (wb_valid && wb_ready) begin
            if (wb_cnt < 8) wb_log[wb_cnt] <= wb_tag;
            wb_cnt <= wb_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ins_valid = 0; ins_tag = 0; ins_dirty = 0; ins_data = 0;
        i_tag = 0; i_take = 0; d_tag = 0; d_take = 0;
        wb_ready = 0; flush = 0;
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
    endtask

    // Offer one insert and hold it until accepted (bounded).
    task automatic do_ins(input logic [13:0] t, input logic dy, input logic [63:0] dt);
        int n;
        ins_valid = 1; ins_tag = t; ins_dirty = dy; ins_data = dt;
        #1;
        n = 0;
        while (!ins_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("ins_tmo", 64'(ins_ready), 64'd1);
        @(posedge clk);
        #1;
        ins_valid = 0;
    endtask

    task automatic fill4(input logic [13:0] base, input logic dy, input logic [63:0] dbase);
        for (int k = 0; k < 4; k++) begin
            do_ins(base + 14'(k), dy, dbase + 64'(k));
        end
    endtask

    initial begin
        // Reset state, observed while reset is still held and just after release.
        do_reset();
        rst = 1;
        step();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_i_hit",    64'(i_hit),    64'd0);
        chk("rst_d_hit",    64'(d_hit),    64'd0);
        chk("rst_occ",      64'(occupancy), 64'd0);
        chk("rst_fdone",    64'(flush_done), 64'd0);
        rst = 0;
        #1;
        chk("rst_ins_ready", 64'(ins_ready), 64'd1);

        // Clean full replacement: slot 0 victim, pointer advances to slot 1.
        fill4(14'h10, 1'b0, 64'h110);
        chk("fill_occ", 64'(occupancy), 64'd4);
        i_tag = 14'h12; #1;
        chk("fill_i_hit",  64'(i_hit),  64'd1);
        chk("fill_i_idx",  64'(i_idx),  64'd2);
        chk("fill_i_data", i_data,      64'h112);
        do_ins(14'h14, 1'b0, 64'h114);
        chk("clean_wb_valid", 64'(wb_valid), 64'd0);
        d_tag = 14'h14; i_tag = 14'h10; #1;
        chk("clean_new_idx", 64'(d_idx), 64'd0);
        chk("clean_new_hit", 64'(d_hit), 64'd1);
        chk("clean_old_hit", 64'(i_hit), 64'd0);
        chk("clean_old_data", i_data,    64'd0);
        chk("clean_occ", 64'(occupancy), 64'd4);
        do_ins(14'h15, 1'b0, 64'h115);
        d_tag = 14'h15; i_tag = 14'h11; #1;
        chk("rr_next_idx", 64'(d_idx), 64'd1);
        chk("rr_old_miss", 64'(i_hit), 64'd0);

        // Dual lookup on the same slot, then a take.
        do_reset();
        fill4(14'h10, 1'b0, 64'h110);
        i_tag = 14'h11; d_tag = 14'h11; #1;
        chk("dual_i_idx", 64'(i_idx), 64'd1);
        chk("dual_d_idx", 64'(d_idx), 64'd1);
        chk("dual_hits",  64'({i_hit, d_hit}), 64'd3);
        d_take = 1;
        step();
        d_take = 0; #1;
        chk("take_hits", 64'({i_hit, d_hit}), 64'd0);
        chk("take_occ",  64'(occupancy), 64'd3);

        // Take and insert of the same tag in one cycle: the insert keeps the slot.
        d_tag = 14'h12; d_take = 1;
        ins_valid = 1; ins_tag = 14'h12; ins_dirty = 0; ins_data = 64'h55;
        step();
        d_take = 0; ins_valid = 0; #1;
        chk("tkins_hit",  64'(d_hit),  64'd1);
        chk("tkins_data", d_data,      64'h55);
        chk("tkins_occ",  64'(occupancy), 64'd3);
        do_ins(14'h30, 1'b0, 64'h130);
        i_tag = 14'h30; #1;
        chk("lowest_free_idx", 64'(i_idx), 64'd1);
        chk("refill_occ", 64'(occupancy), 64'd4);

        // Merge into an existing dirty line.
        do_reset();
        do_ins(14'h12, 1'b1, 64'h77);
        do_ins(14'h12, 1'b0, 64'hAB);
        d_tag = 14'h12; #1;
        chk("merge_data",  d_data,          64'hAB);
        chk("merge_dirty", 64'(d_dirty),    64'd1);
        chk("merge_idx",   64'(d_idx),      64'd0);
        chk("merge_occ",   64'(occupancy),  64'd1);

        // Dirty victim with writeback stalled for 5 cycles.
        do_reset();
        fill4(14'h10, 1'b1, 64'h210);
        wb_ready = 0;
        ins_valid = 1; ins_tag = 14'h20; ins_dirty = 0; ins_data = 64'h220;
        #1;
        chk("evict_ins_ready0", 64'(ins_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("evict_wb_valid", 64'(wb_valid), 64'd1);
            chk("evict_wb_tag",   64'(wb_tag),   64'h10);
            chk("evict_ins_ready", 64'(ins_ready), 64'd0);
        end
        chk("evict_wb_data", wb_data, 64'h210);
        wb_ready = 1;
        step();
        wb_ready = 0; #1;
        chk("evict_ready_back", 64'(ins_ready), 64'd1);
        step();
        ins_valid = 0;
        i_tag = 14'h20; d_tag = 14'h10; #1;
        chk("evict_new_idx", 64'(i_idx), 64'd0);
        chk("evict_new_hit", 64'(i_hit), 64'd1);
        chk("evict_old_miss", 64'(d_hit), 64'd0);
        chk("evict_wb_idle", 64'(wb_valid), 64'd0);
        chk("evict_wb_count", 64'(wb_cnt), 64'd1);

        // Flush with two dirty and two clean slots.
        do_reset();
        do_ins(14'h40, 1'b1, 64'h40);
        do_ins(14'h41, 1'b0, 64'h41);
        do_ins(14'h42, 1'b1, 64'h42);
        do_ins(14'h43, 1'b0, 64'h43);
        wb_ready = 1;
        flush = 1;
        step();
        flush = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (flush_done) pulses++;
        end
        chk("flush_pulses", 64'(pulses), 64'd1);
        chk("flush_wb_cnt", 64'(wb_cnt), 64'd2);
        chk("flush_wb0",    64'(wb_log[0]), 64'h40);
        chk("flush_wb1",    64'(wb_log[1]), 64'h42);
        chk("flush_occ",    64'(occupancy), 64'd0);
        chk("flush_ready",  64'(ins_ready), 64'd1);
        wb_ready = 0;

        // Reset during a stalled eviction.
        do_reset();
        fill4(14'h10, 1'b1, 64'h310);
        ins_valid = 1; ins_tag = 14'h20; ins_dirty = 1; ins_data = 64'h320;
        step();
        step();
        chk("abort_wb_before", 64'(wb_valid), 64'd1);
        rst = 1;
        step();
        ins_valid = 0;
        chk("abort_wb_valid", 64'(wb_valid), 64'd0);
        chk("abort_occ",      64'(occupancy), 64'd0);
        rst = 0; #1;
        chk("abort_ins_ready", 64'(ins_ready), 64'd1);
        step();
        step();
        chk("abort_wb_stays", 64'(wb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
